mem_arbiter: RTL

Two-port arbiter and access sequencer for the 128x8 asynchronous-strobe memory. Requester 0 is instruction fetch and requester 1 is data load/store. Each transaction wins the single memory through round-robin arbitration. The block then drives the memory with a fixed setup / strobe / hold sequence and returns read data plus a one-cycle acknowledge to the winning requester.

---
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter and access sequencer for a 128x8
// asynchronous-strobe memory. Port 0 is instruction fetch and port 1 is
// data load/store. Each granted access runs IDLE -> SETUP -> STROBE -> HOLD.
// mem_en is high for STROBE_CYCLES cycles. The winner's ack pulses during HOLD.
//
// Optional build macro: MEM_ARB_FIXED_PRI_EN
//   defined   : fixed priority, port 0 wins every tie
//   undefined : round-robin, the port not granted last wins a tie
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req/we/addr/wdata 0,1         requester inputs (req held until ack)
//   ack0/1, rdata0/1              one-cycle completion pulse, read data
//   mem_en/read/write/address/
//   mem_input_data                memory strobe and controls (registered)
//   mem_output_data               memory read data
//   busy                          high whenever the sequencer is not IDLE
module mem_arbiter #(
  parameter int ADDR_W        = 7,
  parameter int DATA_W        = 8,
  parameter int STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_input_data,
  input  logic [DATA_W-1:0] mem_output_data,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  // The counter is loaded with STROBE_CYCLES-1 and runs down to 0. The
  // cycle in which it reads 0 is the last strobe cycle.
  localparam logic [3:0] CNT_INIT = 4'(STROBE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_q, last_d;   // port granted most recently
  logic                gnt_q, gnt_d;     // port owning the current access
  logic                en_q, en_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                busy_q, busy_d;
  logic                win;

`ifdef MEM_ARB_FIXED_PRI_EN
  // Port 1 wins only when port 0 is not requesting.
  assign win = ~req0;
`else
  // Under contention the port that was not granted last wins.
  assign win = (req0 & req1) ? ~last_q : ~req0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    en_d     = 1'b0;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          gnt_d   = win;
          last_d  = win;
          wr_d    = win ? we1 : we0;
          rd_d    = ~(win ? we1 : we0);
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        en_d    = 1'b1;
        cnt_d   = CNT_INIT;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          // Last strobe cycle. Capture read data and raise the ack for HOLD.
          state_d = S_HOLD;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          if (rd_q) begin
            if (gnt_q) rdata1_d = mem_output_data;
            else       rdata0_d = mem_output_data;
          end
        end else begin
          en_d  = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      en_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      en_q     <= en_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
    end
  end

  assign mem_en         = en_q;
  assign mem_read       = rd_q;
  assign mem_write      = wr_q;
  assign mem_address    = addr_q;
  assign mem_input_data = wdata_q;
  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign busy           = busy_q;

endmodule
